// File: rtl/im_obj_render_if.sv
// Object-render bus: shadow-table write port, VGA pixel request and
// composited pixel response of im_obj_render grouped in one bundle.
// master = register file / VGA timing side, slave = im_obj_render.
interface im_obj_render_if #(
    parameter int N_OBJ   = 3,
    parameter int COORD_W = 10,
    parameter int RGB_W   = 12
);
    localparam int SEL_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic               obj_wr_en;
    logic [SEL_W-1:0]   obj_wr_sel;
    logic [1:0]         obj_wr_field;
    logic [31:0]        obj_wr_data;

    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;

    logic               rgb_valid;
    logic [RGB_W-1:0]   rgb;
    logic               frame_done;
    logic [15:0]        frame_cnt;
    logic [N_OBJ-1:0]   coll_flags;

    modport master (
        output obj_wr_en, obj_wr_sel, obj_wr_field, obj_wr_data,
        output pix_valid, pix_x, pix_y,
        input  rgb_valid, rgb, frame_done, frame_cnt, coll_flags
    );

    modport slave (
        input  obj_wr_en, obj_wr_sel, obj_wr_field, obj_wr_data,
        input  pix_valid, pix_x, pix_y,
        output rgb_valid, rgb, frame_done, frame_cnt, coll_flags
    );
endinterface

// File: rtl/im_obj_render.sv
// im_obj_render: composites N_OBJ rectangles over a background colour for
// each pixel presented by the VGA timing block. Attribute writes go to a
// shadow table that is copied to the active table on the last visible
// pixel of a frame, so a frame is never drawn with a half-updated table.
// Two-stage pipeline: stage 1 hit test, stage 2 priority select.
// Optional build macro: IM_COLLISION_EN (per-frame ball collision flags).
module im_obj_render #(
    parameter int               N_OBJ    = 3,
    parameter int               COORD_W  = 10,
    parameter int               RGB_W    = 12,
    parameter int               SCREEN_W = 640,
    parameter int               SCREEN_H = 480,
    parameter logic [RGB_W-1:0] BG_RGB   = 12'hAAA
) (
    input logic            clk,
    input logic            rst,
    im_obj_render_if.slave bus
);
    localparam int SEL_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        FLD_LOC  = 2'd0,
        FLD_SIZE = 2'd1,
        FLD_RGB  = 2'd2,
        FLD_EN   = 2'd3
    } field_e;

    // shadow table (write side)
    logic [COORD_W-1:0] sh_x   [N_OBJ];
    logic [COORD_W-1:0] sh_y   [N_OBJ];
    logic [COORD_W-1:0] sh_w   [N_OBJ];
    logic [COORD_W-1:0] sh_h   [N_OBJ];
    logic [RGB_W-1:0]   sh_rgb [N_OBJ];
    logic [N_OBJ-1:0]   sh_en;

    // active table (render side)
    logic [COORD_W-1:0] act_x   [N_OBJ];
    logic [COORD_W-1:0] act_y   [N_OBJ];
    logic [COORD_W-1:0] act_w   [N_OBJ];
    logic [COORD_W-1:0] act_h   [N_OBJ];
    logic [RGB_W-1:0]   act_rgb [N_OBJ];
    logic [N_OBJ-1:0]   act_en;

    field_e             wr_field;
    logic               commit;
    logic [N_OBJ-1:0]   hit;

    logic               s1_valid;
    logic [N_OBJ-1:0]   s1_hit;
    logic [RGB_W-1:0]   s1_rgb [N_OBJ];
    logic [RGB_W-1:0]   sel_rgb;

    logic               rgb_valid_q;
    logic [RGB_W-1:0]   rgb_q;
    logic               frame_done_q;
    logic [15:0]        frame_cnt_q;

    assign wr_field = field_e'(bus.obj_wr_field);
    assign commit   = bus.pix_valid && (bus.pix_x == LAST_X) && (bus.pix_y == LAST_Y);

    // Shadow table writes; indices with no object never match and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_w[i]   <= '0;
                sh_h[i]   <= '0;
                sh_rgb[i] <= '0;
            end
            sh_en <= '0;
        end else if (bus.obj_wr_en) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                if (bus.obj_wr_sel == SEL_W'(i)) begin
                    case (wr_field)
                        FLD_LOC: begin
                            sh_x[i] <= bus.obj_wr_data[COORD_W-1:0];
                            sh_y[i] <= bus.obj_wr_data[16 +: COORD_W];
                        end
                        FLD_SIZE: begin
                            sh_w[i] <= bus.obj_wr_data[COORD_W-1:0];
                            sh_h[i] <= bus.obj_wr_data[16 +: COORD_W];
                        end
                        FLD_RGB: sh_rgb[i] <= bus.obj_wr_data[RGB_W-1:0];
                        FLD_EN:  sh_en[i]  <= bus.obj_wr_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active table takes the shadow contents on the frame's last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_w[i]   <= '0;
                act_h[i]   <= '0;
                act_rgb[i] <= '0;
            end
            act_en <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                act_x[i]   <= sh_x[i];
                act_y[i]   <= sh_y[i];
                act_w[i]   <= sh_w[i];
                act_h[i]   <= sh_h[i];
                act_rgb[i] <= sh_rgb[i];
            end
            act_en <= sh_en;
        end
    end

    // Hit test against the active table; upper bounds use one extra bit so
    // objects running past the screen edge clip instead of wrapping.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            hit[i] = act_en[i]
                && (bus.pix_x >= act_x[i])
                && ({1'b0, bus.pix_x} < ({1'b0, act_x[i]} + {1'b0, act_w[i]}))
                && (bus.pix_y >= act_y[i])
                && ({1'b0, bus.pix_y} < ({1'b0, act_y[i]} + {1'b0, act_h[i]}));
        end
    end

    // Stage 1: hit vector, valid, and the colours of the table that was
    // hit-tested, so the commit pixel still resolves with the old colours.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                s1_rgb[i] <= '0;
            end
        end else begin
            s1_valid <= bus.pix_valid;
            s1_hit   <= hit;
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                s1_rgb[i] <= act_rgb[i];
            end
        end
    end

    // Priority select: lowest-index hitting object wins, else background.
    always_comb begin
        logic found;
        sel_rgb = BG_RGB;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (s1_hit[i] && !found) begin
                sel_rgb = s1_rgb[i];
                found   = 1'b1;
            end
        end
    end

    // Stage 2: qualified pixel output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            rgb_valid_q <= s1_valid;
            rgb_q       <= s1_valid ? sel_rgb : '0;
        end
    end

    // Frame bookkeeping: done pulse follows the commit edge by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= commit;
            if (commit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign bus.rgb_valid  = rgb_valid_q;
    assign bus.rgb        = rgb_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;

`ifdef IM_COLLISION_EN
    logic [N_OBJ-1:0] acc;
    logic [N_OBJ-1:0] coll_q;
    logic [N_OBJ-1:0] s1_coll;
    logic [N_OBJ-1:0] px_coll;
    logic             s1_commit;

    // At the commit edge the previous pixel sits in stage 1 and the commit
    // pixel is still combinational, so both are folded in directly; the
    // commit pixel is then kept out of the next frame's accumulator.
    assign s1_coll = s1_hit & {N_OBJ{s1_hit[0] & s1_valid & ~s1_commit}} & ~N_OBJ'(1);
    assign px_coll = hit & {N_OBJ{hit[0] & bus.pix_valid}} & ~N_OBJ'(1);

    // Per-frame ball collision accumulation, published at commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            coll_q    <= '0;
            s1_commit <= 1'b0;
        end else begin
            s1_commit <= commit;
            if (commit) begin
                coll_q <= acc | s1_coll | px_coll;
                acc    <= '0;
            end else begin
                acc <= acc | s1_coll;
            end
        end
    end

    assign bus.coll_flags = coll_q;
`else
    assign bus.coll_flags = '0;
`endif

endmodule

// File: tb/tb_im_obj_render.sv
// Directed self-checking bench for im_obj_render (N_OBJ=3, 640x480).
// A "frame" here is a few sample pixels followed by the (639,479) commit pixel.
module tb_im_obj_render;
    localparam logic [11:0] BG = 12'hAAA;
`ifdef IM_COLLISION_EN
    localparam logic [2:0] COLL_EXP = 3'b100;
`else
    localparam logic [2:0] COLL_EXP = 3'b000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    im_obj_render_if #(.N_OBJ(3), .COORD_W(10), .RGB_W(12)) bus ();

    im_obj_render #(
        .N_OBJ(3), .COORD_W(10), .RGB_W(12),
        .SCREEN_W(640), .SCREEN_H(480), .BG_RGB(12'hAAA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int sel, input int fld, input logic [31:0] d);
        @(negedge clk);
        bus.obj_wr_en    = 1'b1;
        bus.obj_wr_sel   = 2'(sel);
        bus.obj_wr_field = 2'(fld);
        bus.obj_wr_data  = d;
        @(negedge clk);
        bus.obj_wr_en = 1'b0;
    endtask

    task automatic set_obj(input int sel, input int x, input int y, input int w, input int h,
                           input logic [11:0] col, input logic en);
        wr(sel, 0, (32'(y) << 16) | 32'(x));
        wr(sel, 1, (32'(h) << 16) | 32'(w));
        wr(sel, 2, 32'(col));
        wr(sel, 3, 32'(en));
    endtask

    // One isolated pixel: no output one cycle after, output two cycles after.
    task automatic render(input int x, input int y, input logic [11:0] exp, input string tag);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk({tag, "_lat"}, 32'(bus.rgb_valid), 0);
        @(negedge clk);
        chk({tag, "_v"}, 32'(bus.rgb_valid), 1);
        chk({tag, "_rgb"}, 32'(bus.rgb), 32'(exp));
    endtask

    // Commit pixel, optionally with a simultaneous shadow write.
    task automatic commit_px(input logic [11:0] exp, input int cnt, input string tag,
                             input logic do_wr, input int sel, input int fld, input logic [31:0] d);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'd639;
        bus.pix_y     = 10'd479;
        if (do_wr) begin
            bus.obj_wr_en    = 1'b1;
            bus.obj_wr_sel   = 2'(sel);
            bus.obj_wr_field = 2'(fld);
            bus.obj_wr_data  = d;
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.obj_wr_en = 1'b0;
        chk({tag, "_fd1"}, 32'(bus.frame_done), 1);
        chk({tag, "_cnt"}, 32'(bus.frame_cnt), 32'(cnt));
        chk({tag, "_lat"}, 32'(bus.rgb_valid), 0);
        @(negedge clk);
        chk({tag, "_fd0"}, 32'(bus.frame_done), 0);
        chk({tag, "_v"}, 32'(bus.rgb_valid), 1);
        chk({tag, "_rgb"}, 32'(bus.rgb), 32'(exp));
    endtask

    initial begin
        int          bx[4];
        logic [11:0] be[4];

        bus.obj_wr_en    = 1'b0;
        bus.obj_wr_sel   = '0;
        bus.obj_wr_field = '0;
        bus.obj_wr_data  = '0;
        bus.pix_valid    = 1'b0;
        bus.pix_x        = '0;
        bus.pix_y        = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rgb_valid", 32'(bus.rgb_valid), 0);
        chk("rst_rgb", 32'(bus.rgb), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        chk("rst_coll", 32'(bus.coll_flags), 0);
        rst = 1'b0;

        // frame with no objects: all background; out-of-range pixels never commit
        render(0, 0, BG, "f1_origin");
        render(320, 240, BG, "f1_mid");
        render(700, 479, BG, "f1_oor_x");
        render(639, 500, BG, "f1_oor_y");
        chk("f1_no_commit_cnt", 32'(bus.frame_cnt), 0);
        commit_px(BG, 1, "c1", 1'b0, 0, 0, 0);

        // obj1 at (20,100) 8x60 red; invisible until the next commit
        set_obj(1, 20, 100, 8, 60, 12'hF00, 1'b1);
        render(20, 100, BG, "f2_shadow_only");
        commit_px(BG, 2, "c2", 1'b0, 0, 0, 0);
        render(20, 100, 12'hF00, "f3_tl");
        render(27, 159, 12'hF00, "f3_br");
        render(28, 100, BG, "f3_right_out");
        render(20, 160, BG, "f3_below_out");

        // back-to-back pixels across obj1's left/right edges
        bx = '{19, 20, 27, 28};
        be = '{BG, 12'hF00, 12'hF00, BG};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                bus.pix_valid = 1'b1;
                bus.pix_x     = 10'(bx[k]);
                bus.pix_y     = 10'd120;
            end else begin
                bus.pix_valid = 1'b0;
            end
            if (k >= 2) begin
                chk("burst_v", 32'(bus.rgb_valid), 1);
                chk("burst_rgb", 32'(bus.rgb), 32'(be[k-2]));
            end
        end
        @(negedge clk);
        chk("burst_gap", 32'(bus.rgb_valid), 0);
        commit_px(BG, 3, "c3", 1'b0, 0, 0, 0);

        // obj0 green and obj2 blue overlap; lowest index wins
        set_obj(0, 200, 200, 10, 10, 12'h0F0, 1'b1);
        set_obj(2, 205, 205, 10, 10, 12'h00F, 1'b1);
        commit_px(BG, 4, "c4", 1'b0, 0, 0, 0);
        render(207, 207, 12'h0F0, "f5_overlap");
        render(212, 212, 12'h00F, "f5_obj2_only");
        render(202, 202, 12'h0F0, "f5_obj0_only");
        wr(0, 3, 32'd0);
        render(207, 207, 12'h0F0, "f5_disable_pending");
        commit_px(BG, 5, "c5", 1'b0, 0, 0, 0);
        chk("coll_after_overlap", 32'(bus.coll_flags), 32'(COLL_EXP));
        render(207, 207, 12'h00F, "f6_obj0_off");
        commit_px(BG, 6, "c6", 1'b0, 0, 0, 0);
        chk("coll_after_clean", 32'(bus.coll_flags), 0);

        // right-edge clipping, zero width, out-of-range select
        wr(1, 0, (32'd0 << 16) | 32'd636);
        wr(1, 1, (32'd5 << 16) | 32'd10);
        wr(2, 1, (32'd10 << 16) | 32'd0);
        wr(3, 2, 32'h0FF);
        wr(3, 0, 32'd0);
        commit_px(BG, 7, "c7", 1'b0, 0, 0, 0);
        render(636, 0, 12'hF00, "f8_edge_l");
        render(639, 4, 12'hF00, "f8_edge_r");
        render(0, 0, BG, "f8_nowrap_0");
        render(5, 0, BG, "f8_nowrap_5");
        render(639, 5, BG, "f8_below");
        render(207, 207, BG, "f8_w0");

        // write on the commit cycle, commit pixel rendered with old table
        set_obj(2, 630, 470, 10, 10, 12'h00F, 1'b1);
        commit_px(BG, 8, "c8", 1'b1, 1, 2, 32'h123);
        render(636, 0, 12'hF00, "f9_old_col");
        commit_px(12'h00F, 9, "c9", 1'b0, 0, 0, 0);
        render(636, 0, 12'h123, "f10_new_col");

        // reset mid-stream
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'd636;
        bus.pix_y     = 10'd1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_stream_v", 32'(bus.rgb_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_v", 32'(bus.rgb_valid), 0);
        chk("mid_rst_cnt", 32'(bus.frame_cnt), 0);
        chk("mid_rst_rgb", 32'(bus.rgb), 0);
        bus.pix_valid = 1'b0;
        rst = 1'b0;
        render(636, 0, BG, "post_rst_clear");
        commit_px(BG, 1, "c_post", 1'b0, 0, 0, 0);
        render(636, 0, BG, "post_rst_active_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/im_obj_render.md
Name: im_obj_render

Overview:
- Parametrised successor to the fixed-colour image memory driver for the Pong display.
- Composites N_OBJ rectangular objects (ball, left bar, right bar and extras) over a background colour for every pixel the VGA timing block presents.
- Object attributes are written into a shadow table and committed to the active table only at end of frame, so updates never tear.
- Sits between the IOb register file (write side) and the VGA controller (pixel side).

Parameters:
- N_OBJ, 3, number of objects; index 0 is the ball.
- COORD_W, 10, coordinate width of x, y, w and h.
- RGB_W, 12, colour width.
- SCREEN_W, 640, visible width; last pixel x = SCREEN_W-1.
- SCREEN_H, 480, visible height; last pixel y = SCREEN_H-1.
- BG_RGB, 12'hAAA, background colour.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- obj_wr_en  in  1  write strobe to the shadow table
- obj_wr_sel  in  $clog2(N_OBJ) (min 1)  object index
- obj_wr_field  in  2  field select: 0 = location {y[25:16], x[9:0]}, 1 = size {h[25:16], w[9:0]}, 2 = colour [RGB_W-1:0], 3 = enable [0]
- obj_wr_data  in  32  write data
- pix_valid  in  1  pixel coordinate valid (visible region)
- pix_x  in  COORD_W  pixel column
- pix_y  in  COORD_W  pixel row
- rgb_valid  out  1  rgb qualifier
- rgb  out  RGB_W  composited colour
- frame_done  out  1  one-cycle pulse when the frame commits
- frame_cnt  out  16  committed-frame counter
- coll_flags  out  N_OBJ  collision flags (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): all shadow and active entries cleared (disabled, x/y/w/h/colour = 0); pipeline flushed. Outputs: rgb_valid=0, rgb=0, frame_done=0, frame_cnt=0, coll_flags=0. A reset mid-frame discards in-flight pixels; the next frame starts clean.
- Writes: with obj_wr_en=1, the selected shadow field updates at the clock edge. If obj_wr_sel >= N_OBJ, the write is ignored. The active table is unaffected by writes.
- Commit: occurs when the accepted pixel has pix_valid=1, pix_x=SCREEN_W-1 and pix_y=SCREEN_H-1.
  - On that edge: active <= shadow, frame_cnt increments (wraps 16'hFFFF -> 0), and frame_done pulses on the following cycle.
  - A write on the commit cycle lands in the shadow only and is not part of this commit.
  - The commit pixel itself is rendered with the old active table.
- Hit test, stage 1: object i hits when all of the following hold:
  - enable=1
  - x_i <= pix_x < x_i + w_i
  - y_i <= pix_y < y_i + h_i
  - Sums are computed at COORD_W+1 bits, so there is no wrap and objects crossing the screen edge are clipped.
  - w=0 or h=0 never hits.
  - Stage 1 registers the hit vector and pix_valid.
- Priority, stage 2: the lowest-index hitting object supplies rgb. With no hit, rgb = BG_RGB. When the stage-1 valid is 0, rgb_valid=0 and rgb=0.
- Latency: fixed at 2 cycles from pix_valid to rgb_valid. Throughput is one pixel per cycle. Gaps in pix_valid propagate as gaps in rgb_valid.
- Pixel range: pixels with pix_x >= SCREEN_W or pix_y >= SCREEN_H are still rendered but never trigger a commit.

Optional Feature:
- Macro: IM_COLLISION_EN.
- When defined:
  - Per-frame accumulator acc[i] (i>0) is set when a stage-1 hit vector has both bit 0 and bit i set.
  - At commit, coll_flags <= {acc, 1'b0} including any hit from the commit pixel, and acc clears.
  - coll_flags holds its value until the next commit; bit 0 is always 0.
- When undefined: coll_flags is tied to 0 and no accumulator logic is built.

Test Plan:
1. Reset, then sweep one full 640x480 frame with no writes -> every rgb = 12'hAAA, rgb_valid exactly 2 cycles after each pix_valid, frame_cnt=1, one frame_done pulse.
2. Write obj1 location (x=20, y=100), size (w=8, h=60), colour 12'hF00, enable=1; run two frames -> frame 1 all background; frame 2 shows 12'hF00 at (20,100) and (27,159), and 12'hAAA at (28,100) and (20,160).
3. Overlap obj0 (12'h0F0) and obj2 (12'h00F) on the same region -> 12'h0F0 (lowest index wins); disable obj0 -> 12'h00F from the next frame.
4. Object at x=636, w=10 -> pixels 636..639 coloured with no wrap to x=0..5; w=0 -> never drawn; write with obj_wr_sel=3 (N_OBJ=3) -> no effect.
5. Write obj1 colour on the exact commit cycle -> the following frame uses the old colour, the one after uses the new colour. Assert rst mid-frame -> rgb_valid=0 within 1 cycle and frame_cnt=0.
6. (IM_COLLISION_EN) obj0 overlaps obj2 for one pixel -> coll_flags=3'b100 after commit, 3'b000 after the next clean frame; without the macro coll_flags stays 0.
